// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/ack fetch
// to instruction memory, and feeds IF/ID with stall skid and redirect discard.
module fetch_unit #(
  parameter int                  ADDR_BIT = 10,
  parameter logic [ADDR_BIT-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [ADDR_BIT-1:0] redirect_pc,
  output logic                imem_req,
  output logic [ADDR_BIT-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_data,
  output logic                out_valid,
  output logic [31:0]         inst,
  output logic [ADDR_BIT-1:0] pc_4
);

  typedef enum logic [1:0] {ISSUE, HOLD, DROP} state_t;

  state_t              state_reg;
  logic [ADDR_BIT-1:0] pc_reg;
  logic [ADDR_BIT-1:0] drop_addr_reg;
  logic [ADDR_BIT-1:0] skid_pc4_reg;
  logic [31:0]         skid_inst_reg;
  logic                started_reg;
  logic [ADDR_BIT-1:0] pc_inc;

  // started_reg keeps the request low for the cycle right after reset.
  assign imem_req  = started_reg && (state_reg != HOLD);
  assign imem_addr = (state_reg == DROP) ? drop_addr_reg : pc_reg;
  assign pc_inc    = pc_reg + ADDR_BIT'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ISSUE;
      pc_reg        <= RESET_PC;
      drop_addr_reg <= '0;
      skid_pc4_reg  <= '0;
      skid_inst_reg <= '0;
      started_reg   <= 1'b0;
      out_valid     <= 1'b0;
      inst          <= '0;
      pc_4          <= '0;
    end else begin
      started_reg <= 1'b1;
      if (redirect) begin
        out_valid     <= 1'b0;
        inst          <= '0;
        pc_4          <= '0;
        skid_inst_reg <= '0;
        skid_pc4_reg  <= '0;
        pc_reg        <= redirect_pc;
        case (state_reg)
          ISSUE: begin
            // An unanswered request cannot be withdrawn; finish it in DROP.
            if (imem_req && !imem_ack) begin
              drop_addr_reg <= pc_reg;
              state_reg     <= DROP;
            end else begin
              state_reg <= ISSUE;
            end
          end
          HOLD:    state_reg <= ISSUE;
          DROP:    state_reg <= imem_ack ? ISSUE : DROP;
          default: state_reg <= ISSUE;
        endcase
      end else begin
        case (state_reg)
          ISSUE: begin
            if (imem_req && imem_ack) begin
              pc_reg <= pc_inc;
              if (stall) begin
                skid_inst_reg <= imem_data;
                skid_pc4_reg  <= pc_inc;
                state_reg     <= HOLD;
              end else begin
                inst      <= imem_data;
                pc_4      <= pc_inc;
                out_valid <= 1'b1;
              end
            end else if (!stall) begin
              out_valid <= 1'b0;
              inst      <= '0;
            end
          end
          HOLD: begin
            if (!stall) begin
              inst          <= skid_inst_reg;
              pc_4          <= skid_pc4_reg;
              out_valid     <= 1'b1;
              skid_inst_reg <= '0;
              skid_pc4_reg  <= '0;
              state_reg     <= ISSUE;
            end
          end
          DROP: begin
            out_valid <= 1'b0;
            inst      <= '0;
            if (imem_ack) state_reg <= ISSUE;
          end
          default: state_reg <= ISSUE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: variable-latency memory model plus an expected-output
// queue filled as fetches are set up and drained as IF/ID outputs appear.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] inst;
    logic [9:0]  pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [9:0]  redirect_pc = '0;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        out_valid;
  logic [31:0] inst;
  logic [9:0]  pc_4;

  logic        s_redirect = 1'b0;
  logic [3:0]  s_redirect_pc = '0;
  logic        s_req;
  logic [3:0]  s_addr;
  logic        s_ack;
  logic [31:0] s_data;
  logic        s_valid;
  logic [31:0] s_inst;
  logic [3:0]  s_pc4;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   lat = 0;
  int   cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [9:0] a);
    return 32'hC0DE_0000 | {22'd0, a};
  endfunction

  function automatic logic [31:0] sword(input logic [3:0] a);
    return 32'hC0DE_0000 | {28'd0, a};
  endfunction

  // Memory: answers a request after lat wait cycles, data derived from address.
  always @(posedge clk) begin
    if (!imem_req || imem_ack) cnt <= 0;
    else cnt <= cnt + 1;
  end
  assign imem_ack  = imem_req && (cnt >= lat);
  assign imem_data = word(imem_addr);
  assign s_ack     = s_req;
  assign s_data    = sword(s_addr);

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .out_valid(out_valid), .inst(inst), .pc_4(pc_4)
  );

  fetch_unit #(.ADDR_BIT(4)) u_small (
    .clk(clk), .rst(rst), .stall(stall), .redirect(s_redirect), .redirect_pc(s_redirect_pc),
    .imem_req(s_req), .imem_addr(s_addr), .imem_ack(s_ack), .imem_data(s_data),
    .out_valid(s_valid), .inst(s_inst), .pc_4(s_pc4)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; s_redirect = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    sb.delete();
  endtask

  task automatic push(input logic [9:0] a);
    sb.push_back('{word(a), a + 10'd1});
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || inst !== 32'd0 || pc_4 !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b inst=%h pc_4=%h, want 0/0/0", out_valid, inst, pc_4);
    end
    n_cmp++;
    if (imem_req !== 1'b0 || imem_addr !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_req: req=%b addr=%h, want 0/000", imem_req, imem_addr);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_first_req: req=%b addr=%h, want 1/000", imem_req, imem_addr);
    end
    $display("test_reset done");
  endtask

  task automatic test_zero_wait;
    exp_t e;
    lat = 0;
    do_reset();
    for (int k = 0; k < 4; k++) push(10'(k));
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL zero_wait_valid[%0d]: got %b want 1", i, out_valid);
      end else begin
        e = sb.pop_front();
        if (inst !== e.inst || pc_4 !== e.pc4) begin
          n_fail++;
          $display("FAIL zero_wait_data[%0d]: inst=%h pc_4=%h want %h/%h", i, inst, pc_4, e.inst, e.pc4);
        end
      end
      $display("zero_wait cycle %0d: valid=%b inst=%h pc_4=%h", i, out_valid, inst, pc_4);
    end
  endtask

  task automatic test_wait;
    exp_t e;
    logic waiting;
    logic [9:0] wait_addr;
    lat = 2;
    do_reset();
    for (int k = 0; k < 6; k++) push(10'(k));
    waiting = imem_req && !imem_ack;
    wait_addr = imem_addr;
    for (int cyc = 0; cyc < 40 && sb.size() > 0; cyc++) begin
      tick();
      if (waiting) begin
        n_cmp++;
        if (imem_addr !== wait_addr) begin
          n_fail++;
          $display("FAIL wait_addr_stable: addr=%h want %h", imem_addr, wait_addr);
        end
      end
      n_cmp++;
      if (out_valid) begin
        e = sb.pop_front();
        if (inst !== e.inst || pc_4 !== e.pc4) begin
          n_fail++;
          $display("FAIL wait_data: inst=%h pc_4=%h want %h/%h", inst, pc_4, e.inst, e.pc4);
        end
        $display("wait delivered inst=%h pc_4=%h", inst, pc_4);
      end else if (inst !== 32'd0) begin
        n_fail++;
        $display("FAIL wait_bubble: inst=%h want 0", inst);
      end
      waiting = imem_req && !imem_ack;
      wait_addr = imem_addr;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL wait_timeout: %0d words undelivered, want 0", sb.size());
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_no_dup: valid=%b inst=%h want 0", out_valid, inst);
    end
  endtask

  task automatic test_stall;
    exp_t e;
    lat = 0;
    do_reset();
    for (int k = 0; k < 7; k++) push(10'(k));
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      e = sb.pop_front();
      if (out_valid !== 1'b1 || inst !== e.inst || pc_4 !== e.pc4) begin
        n_fail++;
        $display("FAIL stall_pre[%0d]: v=%b inst=%h pc_4=%h want 1/%h/%h", i, out_valid, inst, pc_4, e.inst, e.pc4);
      end
    end
    n_cmp++;
    if (imem_addr !== 10'd5 || imem_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_setup: addr=%h ack=%b want 005/1", imem_addr, imem_ack);
    end
    stall = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || inst !== word(10'd4) || pc_4 !== 10'd5 || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: v=%b inst=%h pc_4=%h req=%b want 1/%h/005/0", j, out_valid, inst, pc_4, imem_req, word(10'd4));
      end
      $display("stall cycle %0d: inst=%h pc_4=%h req=%b", j, inst, pc_4, imem_req);
    end
    stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      e = sb.pop_front();
      if (out_valid !== 1'b1 || inst !== e.inst || pc_4 !== e.pc4) begin
        n_fail++;
        $display("FAIL stall_post[%0d]: v=%b inst=%h pc_4=%h want 1/%h/%h", i, out_valid, inst, pc_4, e.inst, e.pc4);
      end
      if (i == 0) begin
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 10'd6) begin
          n_fail++;
          $display("FAIL stall_resume: req=%b addr=%h want 1/006", imem_req, imem_addr);
        end
      end
    end
  endtask

  task automatic test_redirect_ack;
    exp_t e;
    lat = 0;
    do_reset();
    for (int k = 0; k < 7; k++) push(10'(k));
    push(10'h20);
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++;
      e = sb.pop_front();
      if (out_valid !== 1'b1 || inst !== e.inst || pc_4 !== e.pc4) begin
        n_fail++;
        $display("FAIL redir_pre[%0d]: inst=%h pc_4=%h want %h/%h", i, inst, pc_4, e.inst, e.pc4);
      end
    end
    redirect = 1'b1; redirect_pc = 10'h20;
    tick();
    redirect = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || inst !== 32'd0 || pc_4 !== 10'd0 || imem_addr !== 10'h20 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL redir_flush: v=%b inst=%h pc_4=%h req=%b addr=%h want 0/0/0/1/020", out_valid, inst, pc_4, imem_req, imem_addr);
    end
    tick();
    n_cmp++;
    e = sb.pop_front();
    if (out_valid !== 1'b1 || inst !== e.inst || pc_4 !== e.pc4) begin
      n_fail++;
      $display("FAIL redir_target: v=%b inst=%h pc_4=%h want 1/%h/%h", out_valid, inst, pc_4, e.inst, e.pc4);
    end
    $display("redirect_ack: inst=%h pc_4=%h", inst, pc_4);
  endtask

  task automatic test_drop;
    exp_t e;
    logic found;
    lat = 2;
    do_reset();
    for (int k = 0; k < 9; k++) push(10'(k));
    push(10'h40);
    found = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      tick();
      if (out_valid) begin
        n_cmp++;
        e = sb.pop_front();
        if (inst !== e.inst || pc_4 !== e.pc4) begin
          n_fail++;
          $display("FAIL drop_pre: inst=%h pc_4=%h want %h/%h", inst, pc_4, e.inst, e.pc4);
        end
      end
      if (imem_req && imem_addr == 10'd9) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL drop_reach9: request for 009 not seen within bound");
    end
    redirect = 1'b1; redirect_pc = 10'h40;
    tick();
    redirect = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 10'd9 || out_valid !== 1'b0 || inst !== 32'd0) begin
      n_fail++;
      $display("FAIL drop_wait1: req=%b addr=%h v=%b inst=%h want 1/009/0/0", imem_req, imem_addr, out_valid, inst);
    end
    tick();
    n_cmp++;
    if (imem_addr !== 10'd9 || imem_ack !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_wait2: addr=%h ack=%b v=%b want 009/1/0", imem_addr, imem_ack, out_valid);
    end
    tick();
    n_cmp++;
    if (imem_addr !== 10'h40 || out_valid !== 1'b0 || inst !== 32'd0) begin
      n_fail++;
      $display("FAIL drop_discard: addr=%h v=%b inst=%h want 040/0/0", imem_addr, out_valid, inst);
    end
    found = 1'b0;
    for (int cyc = 0; cyc < 10 && !found; cyc++) begin
      tick();
      found = out_valid;
    end
    n_cmp++;
    e = sb.pop_front();
    if (!found || inst !== e.inst || pc_4 !== e.pc4) begin
      n_fail++;
      $display("FAIL drop_target: v=%b inst=%h pc_4=%h want 1/%h/%h", out_valid, inst, pc_4, e.inst, e.pc4);
    end
    $display("drop: target inst=%h pc_4=%h", inst, pc_4);
  endtask

  task automatic test_reset_in_drop;
    exp_t e;
    lat = 0;
    do_reset();
    for (int k = 0; k < 3; k++) push(10'(k));
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      e = sb.pop_front();
      if (inst !== e.inst || pc_4 !== e.pc4) begin
        n_fail++;
        $display("FAIL rdrop_pre[%0d]: inst=%h pc_4=%h want %h/%h", i, inst, pc_4, e.inst, e.pc4);
      end
    end
    lat = 2;
    redirect = 1'b1; redirect_pc = 10'h30;
    tick();
    redirect = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 10'd3 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rdrop_in_drop: req=%b addr=%h v=%b want 1/003/0", imem_req, imem_addr, out_valid);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || inst !== 32'd0 || imem_req !== 1'b0 || imem_addr !== 10'd0) begin
      n_fail++;
      $display("FAIL rdrop_reset: v=%b inst=%h req=%b addr=%h want 0/0/0/000", out_valid, inst, imem_req, imem_addr);
    end
    rst = 1'b0;
    lat = 0;
    sb.delete();
    push(10'd0);
    tick();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin
      n_fail++;
      $display("FAIL rdrop_restart: req=%b addr=%h want 1/000", imem_req, imem_addr);
    end
    tick();
    n_cmp++;
    e = sb.pop_front();
    if (out_valid !== 1'b1 || inst !== e.inst || pc_4 !== e.pc4) begin
      n_fail++;
      $display("FAIL rdrop_first: v=%b inst=%h pc_4=%h want 1/%h/%h", out_valid, inst, pc_4, e.inst, e.pc4);
    end
    $display("reset_in_drop: first inst=%h pc_4=%h", inst, pc_4);
  endtask

  task automatic test_wrap;
    exp_t e;
    do_reset();
    sb.push_back('{sword(4'd14), 10'd15});
    sb.push_back('{sword(4'd15), 10'd0});
    sb.push_back('{sword(4'd0),  10'd1});
    s_redirect = 1'b1; s_redirect_pc = 4'd14;
    tick();
    s_redirect = 1'b0;
    n_cmp++;
    if (s_valid !== 1'b0 || s_addr !== 4'd14) begin
      n_fail++;
      $display("FAIL wrap_redirect: v=%b addr=%h want 0/e", s_valid, s_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      e = sb.pop_front();
      if (s_valid !== 1'b1 || s_inst !== e.inst || s_pc4 !== e.pc4[3:0]) begin
        n_fail++;
        $display("FAIL wrap[%0d]: v=%b inst=%h pc_4=%h want 1/%h/%h", i, s_valid, s_inst, s_pc4, e.inst, e.pc4[3:0]);
      end
      $display("wrap cycle %0d: inst=%h pc_4=%h", i, s_inst, s_pc4);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_zero_wait();
    test_wait();
    test_stall();
    test_redirect_ack();
    test_drop();
    test_reset_in_drop();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipeline. Sits directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a req/ack handshake to instruction memory, which may have variable latency.
- Presents {inst, pc_4, out_valid} to IF/ID and handles hazard-unit stalls and branch/jump redirects, including discard of in-flight fetches.

Parameters:
- ADDR_BIT, 10, width of the word address into instruction memory (PC and pc_4 width).
- RESET_PC, 0, word address fetched first after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- stall  input  1  hazard unit: hold fetch output, do not advance.
- redirect  input  1  branch/jump taken: flush and refetch from redirect_pc.
- redirect_pc  input  ADDR_BIT  redirect target word address.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  ADDR_BIT  fetch word address.
- imem_ack  input  1  memory response valid; may arrive in the same cycle as imem_req.
- imem_data  input  32  instruction word, valid when imem_ack is high.
- out_valid  output  1  inst/pc_4 hold a real instruction.
- inst  output  32  fetched instruction; 0 (NOP) when out_valid is 0.
- pc_4  output  ADDR_BIT  fetched address + 1 (next sequential word).

Behaviour:
- Reset (rst=1 at a clk edge), overriding everything:
  - pc=RESET_PC, state=ISSUE, out_valid=0, inst=0, pc_4=0, skid buffer empty, imem_req=0 during the reset cycle.
- imem_req and imem_addr are registered-state driven (combinational from state/pc):
  - imem_req=1 in ISSUE and DROP; imem_req=0 in HOLD.
  - imem_addr=pc in ISSUE; imem_addr=the latched discard address in DROP.
  - While imem_req=1 and no ack, imem_addr stays stable.
- Memory protocol: exactly one request is outstanding; it is never withdrawn before its ack.
- States: ISSUE, HOLD, DROP.
- ISSUE, ack=1, stall=0, redirect=0:
  - inst<=imem_data, pc_4<=pc+1, out_valid<=1, pc<=pc+1; stay in ISSUE.
  - Throughput: 1 inst/cycle with a zero-wait memory.
- ISSUE, ack=1, stall=1, redirect=0:
  - Outputs hold; imem_data goes into a 1-entry skid buffer with its pc+1; pc<=pc+1; go to HOLD.
- ISSUE, ack=0:
  - If stall=1, outputs hold.
  - If stall=0, out_valid<=0 and inst<=0 (bubble).
  - Stay in ISSUE.
- HOLD, stall=1: everything holds; no request.
- HOLD, stall=0: outputs<=skid contents, out_valid<=1, buffer cleared; go to ISSUE.
- Redirect has the highest priority below reset and overrides stall:
  - Always: out_valid<=0, inst<=0, pc_4<=0, skid buffer cleared, pc<=redirect_pc.
  - From ISSUE with ack=1 in the same cycle: response discarded; go to ISSUE.
  - From ISSUE with ack=0 and request outstanding: latch the current address; go to DROP.
  - From HOLD: go to ISSUE.
- DROP:
  - Keep imem_req=1 at the latched address until ack; the ack's data is discarded.
  - Then go to ISSUE, which fetches pc (the redirect target).
  - A further redirect in DROP updates pc only; stay in DROP.
  - Outputs remain invalid (out_valid=0, inst=0).
- PC arithmetic is modulo 2^ADDR_BIT. The max address wraps to 0; pc_4 of the max address is 0.
- Latency: request at cycle N with ack at cycle N → inst visible after edge N+1.
- Outputs are registered; none depend combinationally on inputs, except imem_req/imem_addr on state.

Test Plan:
- Zero-wait memory (ack tied to req), imem_data=addr, 4 cycles after reset → inst=0,1,2,3 on consecutive cycles; pc_4=1,2,3,4; out_valid=1 each cycle.
- Memory acks 2 cycles after req → imem_addr stable across wait cycles; out_valid=0 with inst=0 on wait cycles; each word is delivered exactly once.
- stall held 3 cycles while ack arrives for addr 5 → outputs frozen at addr 4's word; HOLD with no req. After stall drops: inst=word5, pc_4=6, then fetch resumes at 6.
- redirect to 0x20 in the same cycle as ack for addr 7 → addr 7's data never appears. Next cycle out_valid=0 with imem_addr=0x20, then inst=word 0x20, pc_4=0x21.
- redirect to 0x40 while addr 9 is outstanding (ack 2 cycles later) → DROP holds imem_addr=9 until ack; its data is discarded; then request 0x40; no stale instruction appears.
- ADDR_BIT=4, fetch 15 then 0 → pc_4=0 then 1. rst asserted mid-DROP → next cycle pc=RESET_PC, out_valid=0, imem_req=0.
